tune_player: RTL and testbench
==============================

TUNE_PLAYER -- requirements
Module: tune_player

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1: duration counter step is 16 when 1, otherwise 1.
REQ-002 SHALL have parameter DEPTH, default 16: number of note-table entries; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter PER_W, default 15: half-period field width, in clocks.
REQ-004 SHALL have parameter DUR_W, default 4: duration field width, in units.
REQ-005 SHALL have parameter DUR_SHIFT, default 22, legal range ≥ 4: one duration unit is 2^DUR_SHIFT clocks.
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port go, input, 1 bit: start request.
REQ-009 SHALL have port start_addr, input, AW bits: first entry played, sampled with an accepted go.
REQ-010 SHALL have port loop, input, 1 bit: repeat the tune, sampled at the end of the last note.
REQ-011 SHALL have port stop, input, 1 bit: abort playback.
REQ-012 SHALL have ports wr_en (input, 1), wr_addr (input, AW), wr_half_per (input, PER_W), wr_dur (input, DUR_W) and wr_last (input, 1): note-table write port.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse on normal tune completion.
REQ-015 SHALL have port note_idx, output, AW bits: address of the entry currently loaded.
REQ-016 SHALL have ports piezo and piezo_n, outputs, 1 bit each: differential drive.

Function
REQ-017 SHALL hold a DEPTH-entry table of {half_per, dur, last}; a write takes effect on the clock edge when wr_en=1; the table is not cleared by reset.
REQ-018 SHALL implement states IDLE, LOAD and PLAY.
REQ-019 SHALL, in IDLE, move to LOAD when go=1 and stop=0, latching start_addr as both the loop base and note_idx; go SHALL be ignored in LOAD and PLAY.
REQ-020 SHALL, in LOAD (exactly one cycle), register the entry at note_idx (read-before-write on a same-cycle write), clear both counters and go to PLAY.
REQ-021 SHALL, in PLAY, give a note length of exactly (max(dur,1) << DUR_SHIFT) / STEP cycles, where STEP = 16 if FAST_SIM else 1.
REQ-022 SHALL, in PLAY with half_per ≠ 0, set piezo=1 on the first PLAY cycle, toggle it every half_per cycles, and drive piezo_n = ~piezo.
REQ-023 SHALL treat half_per = 0 as a rest: piezo = piezo_n = 0 for the whole note.
REQ-024 SHALL force piezo = piezo_n = 0 in IDLE and LOAD.
REQ-025 SHALL, at note end with last=0, advance note_idx by 1 modulo DEPTH (DEPTH-1 wraps to 0) and go to LOAD.
REQ-026 SHALL, at note end with last=1 and loop=1, reload note_idx from the loop base and go to LOAD, with no done pulse.
REQ-027 SHALL, at note end with last=1 and loop=0, go to IDLE and pulse done for one cycle, coincident with busy falling.
REQ-028 SHALL, when stop=1 in any state, enter IDLE on the next edge with piezo = piezo_n = 0 and no done pulse; stop SHALL win over go and over note end in the same cycle.
REQ-029 SHALL size counters so they never overflow: the duration counter is DUR_W+DUR_SHIFT bits and the half-period counter is PER_W bits.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force state=IDLE, busy=0, done=0, note_idx=0, piezo=0, piezo_n=0, clear all counters and clear the loop base.
REQ-031 SHALL, on reset mid-playback, abort immediately; after reset it SHALL wait for a new go.

Verification (FAST_SIM=1, DUR_SHIFT=8 → 16 cycles/unit, DEPTH=16)
REQ-032 SHALL cover reset: assert rst_n=0 mid-note -> same cycle busy=0, piezo=0, piezo_n=0, done=0.
REQ-033 SHALL cover a single note: entry0={4,2,1}, go with start_addr=0 at cycle 0 -> busy=1 at cycle 1 (LOAD); PLAY for cycles 2-33 with piezo pattern 1111 0000 repeated and piezo_n its complement; done=1 only at cycle 34 with busy=0.
REQ-034 SHALL cover a rest plus wrap: entry15={0,1,0} and entry0={3,1,1}, start_addr=15 -> 16 cycles with both outputs 0, a LOAD cycle with note_idx=0, a 16-cycle tone toggling every 3 cycles, then done.
REQ-035 SHALL cover loop: loop=1 with the REQ-033 table -> a second LOAD at note_idx=0 with no done; deassert loop -> done after the next note end.
REQ-036 SHALL cover stop and collision: stop at cycle 10 of PLAY -> IDLE next cycle, no done; go and stop in the same IDLE cycle -> remains IDLE.
REQ-037 SHALL cover write during play: write entry0 during its own PLAY -> current note unchanged; the new value is played on the next loop pass.

Source files
------------

// File: rtl/tune_player.sv
// -----------------------------------------------------------------------------
// tune_player
//   Plays a tune from a small writable note table. Each table entry holds a
//   half-period (clocks, 0 = rest), a duration (units of 2^DUR_SHIFT clocks,
//   0 treated as 1) and a last-note flag. A tone drives a differential square
//   wave on piezo/piezo_n. Silence is both outputs low.
//
// Ports
//   clk, rst_n       : system clock, asynchronous active-low reset
//   go, start_addr   : start request and first entry to play (sampled in IDLE)
//   loop             : replay from start_addr when the last note ends
//   stop             : abort playback immediately (wins over everything)
//   wr_en, wr_addr, wr_half_per, wr_dur, wr_last : note-table write port
//   busy             : high whenever the player is not IDLE
//   done             : one-cycle pulse on normal completion
//   note_idx         : table address of the note currently loaded
//   piezo, piezo_n   : differential speaker drive
// -----------------------------------------------------------------------------
module tune_player #(
  parameter int FAST_SIM  = 1,
  parameter int DEPTH     = 16,
  parameter int PER_W     = 15,
  parameter int DUR_W     = 4,
  parameter int DUR_SHIFT = 22,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [AW-1:0]    start_addr,
  input  logic             loop,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PER_W-1:0] wr_half_per,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic             wr_last,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    note_idx,
  output logic             piezo,
  output logic             piezo_n
);

  // Duration counter is wide enough to hold the full note length in clock
  // units, so it can never overflow even for the longest note.
  localparam int            CW   = DUR_W + DUR_SHIFT;
  localparam logic [CW-1:0] STEP = (FAST_SIM != 0) ? CW'(16) : CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  typedef struct packed {
    logic [PER_W-1:0] half_per;
    logic [DUR_W-1:0] dur;
    logic             last;
  } note_t;

  state_t           state;
  note_t            table_q [DEPTH];
  note_t            cur_q;
  logic [AW-1:0]    base_q;
  logic [CW-1:0]    dur_cnt;
  logic [PER_W-1:0] hp_cnt;

  logic [DUR_W-1:0] dur_eff;
  logic [CW-1:0]    dur_last;
  logic             note_end;
  logic             hp_wrap;
  logic [AW-1:0]    next_idx;

  // NOTE: the note table has no reset; its contents survive rst_n and only
  // change through the write port, so it is kept out of the reset block.
  always_ff @(posedge clk) begin
    if (wr_en) table_q[wr_addr] <= '{half_per: wr_half_per, dur: wr_dur, last: wr_last};
  end

  // A zero duration plays as one unit. The counter advances by STEP per PLAY
  // cycle; the note ends on the cycle where it holds its final value.
  assign dur_eff  = (cur_q.dur == '0) ? DUR_W'(1) : cur_q.dur;
  assign dur_last = {dur_eff, {DUR_SHIFT{1'b0}}} - STEP;
  assign note_end = (dur_cnt == dur_last);
  assign hp_wrap  = (hp_cnt == cur_q.half_per - PER_W'(1));
  assign next_idx = (note_idx == AW'(DEPTH - 1)) ? '0 : note_idx + AW'(1);

  // NOTE: all state is updated with non-blocking assignments, so the LOAD read
  // of table_q sees the pre-edge contents even when a write lands that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      note_idx <= '0;
      piezo    <= 1'b0;
      piezo_n  <= 1'b0;
      dur_cnt  <= '0;
      hp_cnt   <= '0;
      base_q   <= '0;
      cur_q    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        busy    <= 1'b0;
        piezo   <= 1'b0;
        piezo_n <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (go) begin
              state    <= LOAD;
              busy     <= 1'b1;
              base_q   <= start_addr;
              note_idx <= start_addr;
            end
          end
          LOAD: begin
            cur_q   <= table_q[note_idx];
            dur_cnt <= '0;
            hp_cnt  <= '0;
            state   <= PLAY;
            // First PLAY cycle is high for a tone, silent for a rest.
            piezo   <= (table_q[note_idx].half_per != '0);
            piezo_n <= 1'b0;
          end
          PLAY: begin
            if (note_end) begin
              piezo   <= 1'b0;
              piezo_n <= 1'b0;
              if (!cur_q.last) begin
                note_idx <= next_idx;
                state    <= LOAD;
              end else if (loop) begin
                note_idx <= base_q;
                state    <= LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              dur_cnt <= dur_cnt + STEP;
              if (cur_q.half_per != '0) begin
                if (hp_wrap) begin
                  hp_cnt  <= '0;
                  piezo   <= ~piezo;
                  piezo_n <= piezo;
                end else begin
                  hp_cnt <= hp_cnt + PER_W'(1);
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_player.sv
// -----------------------------------------------------------------------------
// tb_tune_player
//   Scoreboard bench for tune_player (FAST_SIM=1, DUR_SHIFT=8: 16 cycles per
//   duration unit). Stimulus pushes one expected output row per clock cycle;
//   a monitor pops and compares one row at every falling edge.
// -----------------------------------------------------------------------------
module tb_tune_player;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int PER_W = 15;
  localparam int DUR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go = 1'b0;
  logic [AW-1:0]    start_addr = '0;
  logic             loop = 1'b0;
  logic             stop = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [PER_W-1:0] wr_half_per = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic             wr_last = 1'b0;
  logic             busy, done, piezo, piezo_n;
  logic [AW-1:0]    note_idx;

  tune_player #(
    .FAST_SIM(1), .DEPTH(DEPTH), .PER_W(PER_W), .DUR_W(DUR_W), .DUR_SHIFT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .start_addr(start_addr), .loop(loop),
    .stop(stop), .wr_en(wr_en), .wr_addr(wr_addr), .wr_half_per(wr_half_per),
    .wr_dur(wr_dur), .wr_last(wr_last), .busy(busy), .done(done),
    .note_idx(note_idx), .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic          p;
    logic          pn;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    row      = 0;
  string test_name = "reset";

  // Monitor: one expected row per cycle while the scoreboard holds entries.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{busy: busy, done: done, idx: note_idx, p: piezo, pn: piezo_n};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s row %0d: got busy=%b done=%b idx=%0d piezo=%b piezo_n=%b, want busy=%b done=%b idx=%0d piezo=%b piezo_n=%b",
                 test_name, row, a.busy, a.done, a.idx, a.p, a.pn,
                 e.busy, e.done, e.idx, e.p, e.pn);
      end
      row++;
    end
  end

  task automatic push(input logic b, input logic d, input logic [AW-1:0] i,
                      input logic p, input logic pn);
    exp_t e;
    e = '{busy: b, done: d, idx: i, p: p, pn: pn};
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input logic [AW-1:0] i, input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, i, 1'b0, 1'b0);
  endtask

  task automatic push_load(input logic [AW-1:0] i);
    push(1'b1, 1'b0, i, 1'b0, 1'b0);
  endtask

  // n PLAY cycles of a note: high for hp cycles, low for hp cycles, ...
  task automatic push_play(input logic [AW-1:0] i, input int hp, input int n);
    for (int k = 0; k < n; k++) begin
      logic p;
      p = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 0);
      push(1'b1, 1'b0, i, p, (hp == 0) ? 1'b0 : ~p);
    end
  endtask

  task automatic push_done(input logic [AW-1:0] i);
    push(1'b0, 1'b1, i, 1'b0, 1'b0);
  endtask

  task automatic write_note(input logic [AW-1:0] a, input int hp,
                            input int d, input logic l);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_half_per = PER_W'(hp);
    wr_dur = DUR_W'(d); wr_last = l;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // go high for one cycle (cycle 0); returns just after the edge that starts
  // cycle 1, before that cycle is sampled.
  task automatic kick(input logic [AW-1:0] a, input logic with_stop);
    @(posedge clk); #1;
    go = 1'b1; start_addr = a; stop = with_stop;
    @(posedge clk); #1;
    go = 1'b0; stop = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: got %0d rows pending, want 0", test_name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
  endtask

  initial begin
    // Reset state while rst_n is held low.
    rst_n = 1'b0;
    push_idle(4'd0, 3);
    #22 rst_n = 1'b1;
    wait_drain();

    // Single note {4,2,1}: LOAD, 32 PLAY cycles of 1111 0000, then done.
    test_name = "single"; row = 0;
    write_note(4'd0, 4, 2, 1'b1);
    kick(4'd0, 1'b0);
    push_load(4'd0);
    push_play(4'd0, 4, 32);
    push_done(4'd0);
    push_idle(4'd0, 2);
    wait_drain();

    // Rest at entry 15, wrap to entry 0 tone {3,1,1}.
    test_name = "rest_wrap"; row = 0;
    write_note(4'd15, 0, 1, 1'b0);
    write_note(4'd0, 3, 1, 1'b1);
    kick(4'd15, 1'b0);
    push_load(4'd15);
    push_play(4'd15, 0, 16);
    push_load(4'd0);
    push_play(4'd0, 3, 16);
    push_done(4'd0);
    push_idle(4'd0, 2);
    wait_drain();

    // Zero duration plays as one unit.
    test_name = "dur_zero"; row = 0;
    write_note(4'd7, 5, 0, 1'b1);
    kick(4'd7, 1'b0);
    push_load(4'd7);
    push_play(4'd7, 5, 16);
    push_done(4'd7);
    push_idle(4'd7, 1);
    wait_drain();

    // Loop: second pass with no done, loop dropped during it -> done after.
    test_name = "loop"; row = 0;
    write_note(4'd0, 4, 2, 1'b1);
    loop = 1'b1;
    kick(4'd0, 1'b0);
    push_load(4'd0);
    push_play(4'd0, 4, 32);
    push_load(4'd0);
    push_play(4'd0, 4, 32);
    push_done(4'd0);
    push_idle(4'd0, 2);
    repeat (39) @(posedge clk);
    #1 loop = 1'b0;
    wait_drain();

    // Stop during the tenth PLAY cycle -> IDLE next cycle, no done.
    test_name = "stop"; row = 0;
    kick(4'd0, 1'b0);
    push_load(4'd0);
    push_play(4'd0, 4, 10);
    push_idle(4'd0, 4);
    repeat (10) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_drain();

    // go and stop together in IDLE -> stays IDLE.
    test_name = "go_stop"; row = 0;
    kick(4'd0, 1'b1);
    push_idle(4'd0, 4);
    wait_drain();

    // Rewrite entry 0 during its own PLAY: current note keeps {4,2,1}, the
    // looped pass plays {2,1,1}.
    test_name = "write_play"; row = 0;
    loop = 1'b1;
    kick(4'd0, 1'b0);
    push_load(4'd0);
    push_play(4'd0, 4, 32);
    push_load(4'd0);
    push_play(4'd0, 2, 16);
    push_done(4'd0);
    push_idle(4'd0, 2);
    repeat (4) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_half_per = PER_W'(2); wr_dur = DUR_W'(1); wr_last = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0;
    repeat (34) @(posedge clk);
    #1 loop = 1'b0;
    wait_drain();

    // Asynchronous reset mid-note from entry 3: outputs clear within the cycle.
    test_name = "reset_mid"; row = 0;
    write_note(4'd3, 4, 2, 1'b1);
    kick(4'd3, 1'b0);
    push_load(4'd3);
    push_play(4'd3, 4, 8);
    push_idle(4'd0, 8);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_drain();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
